// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out
// start/data/parity/stop on device falling edges, then sample the ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                          INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      byte_q;
    logic            par_q;
    logic [1:0]      clk_s_q;
    logic [1:0]      dat_s_q;
    logic            clk_prev_q;
    logic            clk_oe_q;
    logic            data_oe_q;
    logic            done_q;
    logic            ack_err_q;
    logic            timeout_q;

    logic            fe;
    logic [2:0]      idx_d;

    assign fe    = clk_prev_q & ~clk_s_q[1];
    assign idx_d = idx_q + 3'd1;

    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout     = timeout_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            byte_q     <= '0;
            par_q      <= 1'b0;
            clk_s_q    <= 2'b11;
            dat_s_q    <= 2'b11;
            clk_prev_q <= 1'b1;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            clk_s_q    <= {clk_s_q[0], ps2_clk_in};
            dat_s_q    <= {dat_s_q[0], ps2_data_in};
            clk_prev_q <= clk_s_q[1];
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (tx_valid) begin
                        byte_q    <= tx_data;
                        par_q     <= ~^tx_data;
                        cnt_q     <= '0;
                        clk_oe_q  <= 1'b1;
                        data_oe_q <= 1'b0;
                        state_q   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_REQ;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_REQ, S_DATA, S_PARITY, S_STOP: begin
                    // Timeout has priority over a coincident falling edge
                    if (cnt_q == TMO_LAST) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= S_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (fe) begin
                            case (state_q)
                                S_REQ: begin
                                    data_oe_q <= ~byte_q[0];
                                    idx_q     <= '0;
                                    state_q   <= S_DATA;
                                end
                                S_DATA: begin
                                    if (idx_q == 3'd7) begin
                                        data_oe_q <= ~par_q;
                                        state_q   <= S_PARITY;
                                    end else begin
                                        data_oe_q <= ~byte_q[idx_d];
                                        idx_q     <= idx_d;
                                    end
                                end
                                S_PARITY: begin
                                    data_oe_q <= 1'b0;
                                    state_q   <= S_STOP;
                                end
                                S_STOP: begin
                                    done_q    <= ~dat_s_q[1];
                                    ack_err_q <= dat_s_q[1];
                                    state_q   <= S_WAIT;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
                S_WAIT: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    if (clk_s_q[1] && dat_s_q[1]) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model
// clocking at a 40-cycle period.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, ack_err, timeout;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(16),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .done(done),
        .ack_err(ack_err),
        .timeout(timeout),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_ackerr = 0;
    int n_tmo = 0;
    int n_inh = 0;
    int n_multi = 0;
    int rdy_bad = 0;
    bit watch = 1'b0;

    int d0, a0, t0, i0, s0, n;
    logic [10:0] bits;

    always @(negedge clk) begin
        if (done) n_done++;
        if (ack_err) n_ackerr++;
        if (timeout) n_tmo++;
        if (ps2_clk_oe) n_inh++;
        if (int'(done) + int'(ack_err) + int'(timeout) > 1) n_multi++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int cnt);
        repeat (cnt) begin
            @(negedge clk);
            if (watch && tx_ready) rdy_bad++;
        end
    endtask

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        watch    = 1'b1;
    endtask

    task automatic wait_req(output int w);
        w = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < 200) begin
            tick(1);
            w++;
        end
        chk("req_seen", 32'(w < 200), 1);
        chk("start_bit", 32'(ps2_data_in), 0);
    endtask

    task automatic pulse_low(input bit poke, input int i);
        dev_clk = 1'b0;
        if (poke && i == 3) begin
            tx_data  = 8'h55;
            tx_valid = 1'b1;
        end
        tick(20);
        tx_valid = 1'b0;
    endtask

    task automatic dev_xfer(input bit ack, input bit poke,
                            output logic [10:0] b);
        int w;
        b = '0;
        wait_req(w);
        tick(10);
        for (int i = 0; i < 11; i++) begin
            pulse_low(poke, i);
            dev_clk = 1'b1;
            b[i] = ps2_data_in;
            if (i == 9 && ack) dev_data = 1'b0;
            if (i == 10) begin
                dev_data = 1'b1;
                watch    = 1'b0;
            end
            tick(20);
        end
    endtask

    initial begin
        tick(3);
        chk("rst_ready", 32'(tx_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
        chk("rst_data_oe", 32'(ps2_data_oe), 0);
        chk("rst_pulses", 32'(done | ack_err | timeout), 0);
        rstn = 1'b1;
        tick(3);

        // 0xED with ack
        d0 = n_done; i0 = n_inh; rdy_bad = 0;
        send(8'hED);
        chk("ed_busy", 32'(busy), 1);
        dev_xfer(1'b1, 1'b0, bits);
        chk("ed_data", 32'(bits[7:0]), 32'hED);
        chk("ed_par", 32'(bits[8]), 1);
        chk("ed_stop", 32'(bits[9]), 1);
        chk("ed_inhibit", n_inh - i0, 16);
        chk("ed_done", n_done - d0, 1);
        chk("ed_rdy_low", rdy_bad, 0);
        chk("ed_idle", 32'(tx_ready), 1);

        // back-to-back 0x00, 0x01
        d0 = n_done; rdy_bad = 0;
        send(8'h00);
        dev_xfer(1'b1, 1'b0, bits);
        chk("b00_data", 32'(bits[7:0]), 32'h00);
        chk("b00_par", 32'(bits[8]), 1);
        send(8'h01);
        dev_xfer(1'b1, 1'b0, bits);
        chk("b01_data", 32'(bits[7:0]), 32'h01);
        chk("b01_par", 32'(bits[8]), 0);
        chk("b2b_done", n_done - d0, 2);
        chk("b2b_rdy_low", rdy_bad, 0);

        // device leaves data high at ack
        d0 = n_done; a0 = n_ackerr;
        send(8'hA5);
        dev_xfer(1'b0, 1'b0, bits);
        chk("nak_data", 32'(bits[7:0]), 32'hA5);
        chk("nak_err", n_ackerr - a0, 1);
        chk("nak_done", n_done - d0, 0);
        tick(2);
        chk("nak_idle", 32'(tx_ready), 1);

        // device never clocks
        t0 = n_tmo; d0 = n_done; a0 = n_ackerr;
        send(8'h3C);
        wait_req(n);
        n = 0;
        while (!timeout && n < 2000) begin
            tick(1);
            n++;
        end
        watch = 1'b0;
        chk("tmo_latency", n, 1000);
        chk("tmo_clk_oe", 32'(ps2_clk_oe), 0);
        chk("tmo_data_oe", 32'(ps2_data_oe), 0);
        tick(3);
        chk("tmo_pulse", n_tmo - t0, 1);
        chk("tmo_other", (n_done - d0) + (n_ackerr - a0), 0);
        chk("tmo_idle", 32'(tx_ready), 1);

        // reset during data bit 4 (0x86 bit4 = 0 -> data pulled low)
        send(8'h86);
        wait_req(n);
        tick(10);
        for (int i = 0; i < 4; i++) begin
            pulse_low(1'b0, i);
            dev_clk = 1'b1;
            tick(20);
        end
        dev_clk = 1'b0;
        tick(10);
        watch = 1'b0;
        chk("rst_pre_oe", 32'(ps2_data_oe), 1);
        s0 = n_done + n_ackerr + n_tmo;
        #1 rstn = 1'b0;
        #1;
        chk("rst_mid_data_oe", 32'(ps2_data_oe), 0);
        chk("rst_mid_clk_oe", 32'(ps2_clk_oe), 0);
        chk("rst_mid_ready", 32'(tx_ready), 1);
        tick(2);
        dev_clk = 1'b1;
        tick(3);
        rstn = 1'b1;
        tick(5);
        chk("rst_no_pulse", (n_done + n_ackerr + n_tmo) - s0, 0);
        d0 = n_done;
        send(8'hF4);
        dev_xfer(1'b1, 1'b0, bits);
        chk("f4_data", 32'(bits[7:0]), 32'hF4);
        chk("f4_par", 32'(bits[8]), 0);
        chk("f4_done", n_done - d0, 1);

        // tx_valid with 0x55 while busy
        d0 = n_done; rdy_bad = 0;
        send(8'hED);
        dev_xfer(1'b1, 1'b1, bits);
        chk("poke_data", 32'(bits[7:0]), 32'hED);
        chk("poke_par", 32'(bits[8]), 1);
        tick(40);
        chk("poke_done", n_done - d0, 1);
        chk("poke_idle", 32'(tx_ready), 1);
        chk("poke_rdy_low", rdy_bad, 0);

        chk("pulse_excl", n_multi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
